// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared definitions for the ID/EX stage: ALU opcode encoding
//               and the operand-forwarding select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    // ALU opcode encoding carried through the stage untouched
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Where a forwarded source operand came from
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    localparam int c_ALU_OP_W = 4;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Per-source forwarding selector. Chooses between the EX/MEM
//               ALU result, the value being retired by WB, and the operand
//               value captured in the ID/EX register. Index 0 never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] i_rs,
    input  logic [XLEN-1:0]    i_stored,
    input  logic [RADDR_W-1:0] i_mem_rd,
    input  logic               i_mem_wb_en,
    input  logic               i_mem_is_load,
    input  logic [XLEN-1:0]    i_mem_rslt,
    input  logic [RADDR_W-1:0] i_wb_rd,
    input  logic               i_wb_wb_en,
    input  logic [XLEN-1:0]    i_wb_data,
    output fwd_sel_e           o_sel,
    output logic [XLEN-1:0]    o_val
);

    logic w_src_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nonzero = (i_rs != '0);
    // A load in MEM has no data yet; the load-use stall keeps it from mattering
    assign w_mem_hit     = w_src_nonzero & i_mem_wb_en & ~i_mem_is_load & (i_mem_rd == i_rs);
    assign w_wb_hit      = w_src_nonzero & i_wb_wb_en & (i_wb_rd == i_rs);

    // Youngest producer wins: MEM before WB before the captured value
    always_comb begin
        o_sel = FWD_REG;
        o_val = i_stored;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
            o_val = i_mem_rslt;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
            o_val = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with valid/ready handshake, load-use
//               hazard stall, WB capture bypass, stall-time operand refresh
//               and combinational MEM/WB forwarding into the ALU operands.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [XLEN-1:0]    id_rs1_val,
    input  logic [XLEN-1:0]    id_rs2_val,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [3:0]         id_opr,
    input  logic               id_use_imm,
    input  logic               id_use_pc,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_wb_en,
    input  logic               id_is_load,
    input  logic               flush,
    input  logic               ex_ready,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_wb_en,
    input  logic               mem_is_load,
    input  logic [XLEN-1:0]    mem_rslt,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_wb_en,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_oprnd1,
    output logic [XLEN-1:0]    ex_oprnd2,
    output logic [3:0]         ex_opr,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_wb_en,
    output logic               ex_is_load
);

    // ID/EX register contents
    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [RADDR_W-1:0] r_rs1;
    logic [RADDR_W-1:0] r_rs2;
    logic [XLEN-1:0]    r_rs1_val;
    logic [XLEN-1:0]    r_rs2_val;
    logic [XLEN-1:0]    r_imm;
    logic [c_ALU_OP_W-1:0] r_opr;
    logic               r_use_imm;
    logic               r_use_pc;
    logic [RADDR_W-1:0] r_rd;
    logic               r_wb_en;
    logic               r_is_load;

    logic               w_adv;
    logic               w_hazard;
    logic               w_capture;
    logic [XLEN-1:0]    w_cap_rs1_val;
    logic [XLEN-1:0]    w_cap_rs2_val;
    logic [XLEN-1:0]    w_hold_rs1_val;
    logic [XLEN-1:0]    w_hold_rs2_val;
    logic [XLEN-1:0]    w_fwd1;
    logic [XLEN-1:0]    w_fwd2;
    fwd_sel_e           w_sel1;
    fwd_sel_e           w_sel2;
    logic               w_unused_sel;

    // The stage can take a new instruction when it is empty or draining
    assign w_adv    = ex_ready | ~r_valid;
    // A load in EX whose result a decoding instruction needs cannot forward in time
    assign w_hazard = r_valid & r_is_load & r_wb_en & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));
    // A flushed instruction is dropped anyway, so the hazard must not block it
    assign id_ready  = w_adv & (flush | ~w_hazard);
    assign w_capture = w_adv & id_valid & ~flush & ~w_hazard;

    // Regfile write happening this cycle is not yet visible in id_rsN_val
    assign w_cap_rs1_val  = (wb_wb_en && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_val;
    assign w_cap_rs2_val  = (wb_wb_en && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_val;
    // While stalled, absorb a retiring producer before it leaves WB
    assign w_hold_rs1_val = (wb_wb_en && (wb_rd != '0) && (wb_rd == r_rs1)) ? wb_data : r_rs1_val;
    assign w_hold_rs2_val = (wb_wb_en && (wb_rd != '0) && (wb_rd == r_rs2)) ? wb_data : r_rs2_val;

    // Pipeline register: capture, bubble, or hold with operand refresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_opr     <= '0;
            r_use_imm <= 1'b0;
            r_use_pc  <= 1'b0;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_is_load <= 1'b0;
        end else if (w_adv) begin
            if (w_capture) begin
                r_valid   <= 1'b1;
                r_pc      <= id_pc;
                r_rs1     <= id_rs1;
                r_rs2     <= id_rs2;
                r_rs1_val <= w_cap_rs1_val;
                r_rs2_val <= w_cap_rs2_val;
                r_imm     <= id_imm;
                r_opr     <= id_opr;
                r_use_imm <= id_use_imm;
                r_use_pc  <= id_use_pc;
                r_rd      <= id_rd;
                r_wb_en   <= id_wb_en;
                r_is_load <= id_is_load;
            end else begin
                r_valid   <= 1'b0;
                r_wb_en   <= 1'b0;
                r_is_load <= 1'b0;
            end
        end else begin
            r_rs1_val <= w_hold_rs1_val;
            r_rs2_val <= w_hold_rs2_val;
        end
    end

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd1 (
        .i_rs          (r_rs1),
        .i_stored      (r_rs1_val),
        .i_mem_rd      (mem_rd),
        .i_mem_wb_en   (mem_wb_en),
        .i_mem_is_load (mem_is_load),
        .i_mem_rslt    (mem_rslt),
        .i_wb_rd       (wb_rd),
        .i_wb_wb_en    (wb_wb_en),
        .i_wb_data     (wb_data),
        .o_sel         (w_sel1),
        .o_val         (w_fwd1)
    );

    fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd2 (
        .i_rs          (r_rs2),
        .i_stored      (r_rs2_val),
        .i_mem_rd      (mem_rd),
        .i_mem_wb_en   (mem_wb_en),
        .i_mem_is_load (mem_is_load),
        .i_mem_rslt    (mem_rslt),
        .i_wb_rd       (wb_rd),
        .i_wb_wb_en    (wb_wb_en),
        .i_wb_data     (wb_data),
        .o_sel         (w_sel2),
        .o_val         (w_fwd2)
    );

    // Select codes are only of interest for debug probing
    assign w_unused_sel = ^{w_sel1, w_sel2};

    assign ex_valid      = r_valid;
    assign ex_oprnd1     = r_use_pc  ? r_pc  : w_fwd1;
    assign ex_oprnd2     = r_use_imm ? r_imm : w_fwd2;
    assign ex_store_data = w_fwd2;
    assign ex_opr        = r_opr;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;
    assign ex_wb_en      = r_wb_en;
    assign ex_is_load    = r_is_load;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed scenarios with
//               literal expectations plus randomized traffic compared each
//               cycle against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_opr;
    logic        id_use_imm, id_use_pc, id_wb_en, id_is_load;
    logic        flush, ex_ready;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_wb_en, mem_is_load, wb_wb_en;
    logic [31:0] mem_rslt, wb_data;
    logic        ex_valid, ex_wb_en, ex_is_load;
    logic [31:0] ex_oprnd1, ex_oprnd2, ex_store_data, ex_pc;
    logic [3:0]  ex_opr;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_opr(id_opr), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
        .id_rd(id_rd), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .flush(flush), .ex_ready(ex_ready),
        .mem_rd(mem_rd), .mem_wb_en(mem_wb_en), .mem_is_load(mem_is_load), .mem_rslt(mem_rslt),
        .wb_rd(wb_rd), .wb_wb_en(wb_wb_en), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_oprnd1(ex_oprnd1), .ex_oprnd2(ex_oprnd2), .ex_opr(ex_opr),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load)
    );

    // ---------------- reference model: the instruction sitting in EX -------
    typedef struct packed {
        bit        v;
        bit [31:0] pc;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] a, b, imm;
        bit [3:0]  opr;
        bit        use_imm, use_pc, wb_en, is_load;
    } rec_t;

    rec_t m;

    function automatic bit wb_writes(input bit [4:0] r);
        return wb_wb_en && (wb_rd != 0) && (wb_rd == r);
    endfunction

    function automatic bit load_use(input rec_t c);
        return c.v && c.is_load && c.wb_en && (c.rd != 0) && id_valid &&
               ((c.rd == id_rs1) || (c.rd == id_rs2));
    endfunction

    // Value an ALU source sees: newest in-flight producer of that register
    function automatic bit [31:0] operand(input bit [4:0] r, input bit [31:0] stored);
        if (r == 0) return stored;
        if (mem_wb_en && !mem_is_load && mem_rd == r) return mem_rslt;
        if (wb_writes(r)) return wb_data;
        return stored;
    endfunction

    function automatic rec_t next_rec(input rec_t c);
        rec_t n = c;
        if (c.v && !ex_ready) begin
            if (wb_writes(c.rs1)) n.a = wb_data;
            if (wb_writes(c.rs2)) n.b = wb_data;
        end else if (id_valid && !flush && !load_use(c)) begin
            n.v = 1; n.pc = id_pc; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.a = wb_writes(id_rs1) ? wb_data : id_rs1_val;
            n.b = wb_writes(id_rs2) ? wb_data : id_rs2_val;
            n.imm = id_imm; n.opr = id_opr; n.use_imm = id_use_imm; n.use_pc = id_use_pc;
            n.wb_en = id_wb_en; n.is_load = id_is_load;
        end else begin
            n.v = 0; n.wb_en = 0; n.is_load = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= next_rec(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: outputs against the model
    always @(negedge clk) begin
        check("m_id_ready", {31'd0, id_ready},
              {31'd0, (!m.v || ex_ready) && (flush || !load_use(m))});
        check("m_ex_valid",   {31'd0, ex_valid},   {31'd0, m.v});
        check("m_ex_wb_en",   {31'd0, ex_wb_en},   {31'd0, m.wb_en});
        check("m_ex_is_load", {31'd0, ex_is_load}, {31'd0, m.is_load});
        if (m.v) begin
            check("m_oprnd1", ex_oprnd1, m.use_pc  ? m.pc  : operand(m.rs1, m.a));
            check("m_oprnd2", ex_oprnd2, m.use_imm ? m.imm : operand(m.rs2, m.b));
            check("m_store",  ex_store_data, operand(m.rs2, m.b));
            check("m_opr",    {28'd0, ex_opr}, {28'd0, m.opr});
            check("m_pc",     ex_pc, m.pc);
            check("m_rd",     {27'd0, ex_rd}, {27'd0, m.rd});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic idle();
        id_valid = 0; flush = 0; ex_ready = 1;
        mem_wb_en = 0; mem_is_load = 0; wb_wb_en = 0;
    endtask

    task automatic present(input bit [4:0] rs1, input bit [4:0] rs2,
                           input bit [31:0] v1, input bit [31:0] v2,
                           input bit [31:0] imm, input bit [3:0] opr,
                           input bit use_imm, input bit [4:0] rd,
                           input bit wb_en, input bit is_load);
        id_valid = 1; id_pc = 32'h100; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_val = v1; id_rs2_val = v2; id_imm = imm; id_opr = opr;
        id_use_imm = use_imm; id_use_pc = 0; id_rd = rd; id_wb_en = wb_en; id_is_load = is_load;
    endtask

    task automatic randomize_inputs();
        id_valid   = ($urandom_range(0, 9) < 8);
        id_pc      = $urandom;
        id_rs1     = 5'($urandom_range(0, 7));
        id_rs2     = 5'($urandom_range(0, 7));
        id_rs1_val = $urandom;
        id_rs2_val = $urandom;
        id_imm     = $urandom;
        id_opr     = 4'($urandom_range(0, 10));
        id_use_imm = ($urandom_range(0, 3) == 0);
        id_use_pc  = ($urandom_range(0, 4) == 0);
        id_rd      = 5'($urandom_range(0, 7));
        id_wb_en   = ($urandom_range(0, 3) != 0);
        id_is_load = ($urandom_range(0, 2) == 0);
        flush      = ($urandom_range(0, 9) == 0);
        ex_ready   = ($urandom_range(0, 3) != 0);
        mem_rd     = 5'($urandom_range(0, 7));
        mem_wb_en  = ($urandom_range(0, 1) == 0);
        mem_is_load= ($urandom_range(0, 3) == 0);
        mem_rslt   = $urandom;
        wb_rd      = 5'($urandom_range(0, 7));
        wb_wb_en   = ($urandom_range(0, 1) == 0);
        wb_data    = $urandom;
    endtask

    initial begin
        rst = 1;
        id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_val = 0; id_rs2_val = 0; id_imm = 0;
        id_opr = 0; id_use_imm = 0; id_use_pc = 0; id_rd = 0; id_wb_en = 0; id_is_load = 0;
        mem_rd = 0; mem_rslt = 0; wb_rd = 0; wb_data = 0;
        idle();
        repeat (2) cyc();
        rst = 0;
        look();
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_oprnd1", ex_oprnd1, 32'd0);
        check("rst_oprnd2", ex_oprnd2, 32'd0);
        check("rst_opr", {28'd0, ex_opr}, 32'd0);
        check("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // MEM forward: SUB reads x5 produced by the ADD now in MEM
        present(5, 6, 32'h999, 32'h3, 0, ALU_SUB, 0, 8, 1, 0);
        cyc();
        id_valid = 0; ex_ready = 0;
        mem_rd = 5; mem_wb_en = 1; mem_rslt = 32'h10;
        look();
        check("memfwd_valid", {31'd0, ex_valid}, 32'd1);
        check("memfwd_oprnd1", ex_oprnd1, 32'h10);
        check("memfwd_opr", {28'd0, ex_opr}, {28'd0, ALU_SUB});

        // MEM beats WB for the same register, then WB alone, then refreshed copy
        cyc();
        idle();
        present(3, 0, 32'h1, 0, 0, ALU_ADD, 0, 4, 1, 0);
        cyc();
        id_valid = 0; ex_ready = 0;
        mem_rd = 3; mem_wb_en = 1; mem_rslt = 32'hAA;
        wb_rd = 3; wb_wb_en = 1; wb_data = 32'h55;
        look();
        check("prio_mem", ex_oprnd1, 32'hAA);
        mem_wb_en = 0;
        cyc(); look();
        check("prio_wb", ex_oprnd1, 32'h55);
        wb_wb_en = 0;
        cyc(); look();
        check("prio_held", ex_oprnd1, 32'h55);

        // Load-use: LW x7 in EX, ADD needs x7 as rs2
        cyc();
        idle();
        present(1, 0, 32'h2000, 0, 32'h4, ALU_ADD, 1, 7, 1, 1);
        cyc();
        present(2, 7, 32'h5, 32'h0, 0, ALU_ADD, 0, 10, 1, 0);
        look();
        check("lu_stall_ready", {31'd0, id_ready}, 32'd0);
        check("lu_ex_is_load", {31'd0, ex_is_load}, 32'd1);
        cyc();
        mem_rd = 7; mem_wb_en = 1; mem_is_load = 1; mem_rslt = 32'h1111;
        look();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        check("lu_ready_again", {31'd0, id_ready}, 32'd1);
        cyc();
        id_valid = 0; mem_wb_en = 0; mem_is_load = 0;
        wb_rd = 7; wb_wb_en = 1; wb_data = 32'hDEADBEEF;
        look();
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_oprnd2", ex_oprnd2, 32'hDEADBEEF);
        check("lu_store", ex_store_data, 32'hDEADBEEF);

        // Stall refresh: held rs1=x9 picks up WB write before it leaves
        cyc();
        idle();
        present(9, 0, 32'h1, 0, 0, ALU_OR, 0, 11, 1, 0);
        cyc();
        id_valid = 0; ex_ready = 0;
        wb_rd = 9; wb_wb_en = 1; wb_data = 32'h1234;
        cyc();
        wb_wb_en = 0;
        look();
        check("refresh_1", ex_oprnd1, 32'h1234);
        cyc(); look();
        check("refresh_2", ex_oprnd1, 32'h1234);

        // Flush drops the decode instruction
        cyc();
        idle();
        present(4, 4, 32'h9, 32'h9, 0, ALU_XOR, 0, 12, 1, 0);
        flush = 1;
        look();
        check("flush_ready", {31'd0, id_ready}, 32'd1);
        cyc();
        flush = 0; id_valid = 0;
        look();
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // x0 is never forwarded
        present(0, 0, 32'h77, 32'h66, 0, ALU_AND, 0, 13, 1, 0);
        cyc();
        id_valid = 0; ex_ready = 0;
        mem_rd = 0; mem_wb_en = 1; mem_rslt = 32'hBAD;
        wb_rd = 0; wb_wb_en = 1; wb_data = 32'hBEE;
        look();
        check("x0_oprnd1", ex_oprnd1, 32'h77);
        check("x0_store", ex_store_data, 32'h66);

        // Randomized traffic with one asynchronous reset mid-run
        for (int i = 0; i < 3000; i++) begin
            cyc();
            randomize_inputs();
            if (i == 1500) begin
                #1 rst = 1;
                #1;
                check("async_rst_valid", {31'd0, ex_valid}, 32'd0);
                check("async_rst_oprnd1", ex_oprnd1, 32'd0);
                check("async_rst_ready", {31'd0, id_ready}, 32'd1);
                rst = 0;
            end
        end

        cyc();
        idle();
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
